uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with a built-in transmit FIFO, configurable data width, parity mode and stop-bit count. It accepts words from the user logic with a ready/valid handshake and serialises them on a single TX line. Consecutive frames are sent back-to-back with no idle gap while the FIFO holds data. It sits between any byte/word producer and the board's UART TX pin, replacing the fixed 8N1 single-byte transmitter.

## Interface
Parameters:
- CLKS_PER_BIT, 217 — i_Clock cycles per UART bit (i_Clock frequency / baud); legal range ≥ 2.
- DATA_BITS, 8 — data bits per frame, 5..8.
- PARITY, 0 — 0 none, 1 odd, 2 even.
- STOP_BITS, 1 — 1 or 2.
- FIFO_DEPTH, 16 — TX FIFO entries; power of two, ≥ 2.

Ports:
- i_Clock  in  1  — single clock; all logic on its rising edge.
- i_Rst  in  1  — reset, synchronous, active-high.
- i_TX_DV  in  1  — write strobe; a word is accepted on a rising edge where i_TX_DV=1 and o_TX_Ready=1.
- i_TX_Byte  in  DATA_BITS  — word to send; sampled on the accepting edge.
- o_TX_Ready  out  1  — FIFO not full (registered).
- o_TX_Serial  out  1  — UART line; idle high.
- o_TX_Active  out  1  — high from the first start-bit cycle until the last stop bit of the last queued frame ends.
- o_TX_Done  out  1  — one-cycle pulse at the end of every frame.
- o_Overflow  out  1  — one-cycle pulse when i_TX_DV=1 while o_TX_Ready=0; the word is dropped.
- o_FIFO_Count  out  $clog2(FIFO_DEPTH)+1  — words currently queued, excluding the frame in flight.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: line high. If the FIFO is non-empty, pop the head into the shift register, clear the counters and enter START.
- START: line 0 for CLKS_PER_BIT cycles, then enter DATA.
- DATA: send DATA_BITS bits LSB first, CLKS_PER_BIT cycles each. After the last bit, enter PARITY if PARITY≠0, otherwise STOP.
- PARITY: even mode sends XOR of the data bits; odd mode sends its inverse. Duration is CLKS_PER_BIT cycles.
- STOP: line 1 for STOP_BITS×CLKS_PER_BIT cycles. On the final cycle, pulse o_TX_Done.
  - If the FIFO is non-empty at that edge, pop the next word and go directly to START, with no idle cycles.
  - Otherwise go to IDLE and drop o_TX_Active.
- Frame length is CLKS_PER_BIT×(1+DATA_BITS+(PARITY≠0)+STOP_BITS) cycles.
- Bit counter: CLKS_PER_BIT-1 down to 0, width $clog2(CLKS_PER_BIT). Bit index: width $clog2(DATA_BITS+1).
- FIFO:
  - A write and a pop on the same edge leave the count unchanged.
  - A write into a full FIFO is dropped and o_Overflow pulses. This holds even if a pop occurs on that edge, because ready is based on the registered count.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Illegal parameter values are rejected at elaboration (generate-time $error).

## Timing
- Reset values: o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_Overflow=0, o_TX_Ready=1, o_FIFO_Count=0. FSM is in IDLE and the FIFO is empty.
- Reset mid-frame aborts the frame and flushes the FIFO. The line is high from the first edge at which i_Rst is sampled high. No o_TX_Done pulse is produced.
- Latency, with the FIFO empty and FSM in IDLE, a word accepted at edge N:
  - o_FIFO_Count=1 after edge N.
  - Pop and entry to START at edge N+1. o_FIFO_Count returns to 0 after edge N+1.
  - o_TX_Serial=0 and o_TX_Active=1 from edge N+2.
- Outputs are registered: every bit period is exactly CLKS_PER_BIT cycles at o_TX_Serial.
- o_TX_Done is high for the cycle after the edge ending the last stop bit. That is the same edge where o_TX_Serial either returns to idle-high or, for back-to-back frames, falls for the next start bit.
- o_TX_Ready falls the cycle after o_FIFO_Count reaches FIFO_DEPTH. It rises the cycle after a pop from full.

## Structure
- Package uart_pkg:
  - parity constants PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2;
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
- Sub-module uart_sync_fifo: single-clock FIFO, parametrised by WIDTH and DEPTH. Ports: write, read, full, empty, count. The receive path reuses it.
- The top level holds the FSM, bit counter, shift register and parity accumulator.

## Test plan
- CLKS_PER_BIT=4, 8N1, write 0x55 into idle → line low at N+2. Then data bits 1,0,1,0,1,0,1,0 at 4 cycles each, stop high for 4 cycles. o_TX_Done pulses once, 40 cycles after the start bit begins.
- DATA_BITS=7, PARITY=2, STOP_BITS=2, send 0x41 → data 1000001 LSB first, parity bit 0, stop high 8 cycles. Frame is 44 cycles.
- PARITY=1, DATA_BITS=8, send 0x07 → parity bit 0 (three ones, odd mode). Send 0x03 → parity bit 1.
- Write 0xA1, 0xB2, 0xC3 on consecutive cycles → three frames with no idle cycle between them. o_TX_Done pulses 3 times. o_TX_Active stays high continuously, falling one frame-length after the third start.
- FIFO_DEPTH=4, hold i_TX_DV for 7 cycles → o_TX_Ready low once 4 are queued. The following writes pulse o_Overflow and are dropped. Only the accepted words appear on the line, in order.
- Assert i_Rst during the DATA bit 3 of a frame with 2 words queued → line high from the first edge i_Rst is sampled high, o_FIFO_Count=0, no o_TX_Done. Nothing further is transmitted after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the UART blocks.
// Imported by the TX path and its FIFO.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Pointers wrap naturally because DEPTH is a power of two.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   write,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   read,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = write && !full;
  assign do_rd = read && !empty;
  assign rdata = mem[rptr];

  // storage write port
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wdata;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + AW'(1);
      if (do_rd) rptr <= rptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a TX FIFO; back-to-back frames while data waits.
// Line outputs are registered, so they trail the FSM state by one cycle.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        i_Clock,
  input  logic                        i_Rst,
  input  logic                        i_TX_DV,
  input  logic [DATA_BITS-1:0]        i_TX_Byte,
  output logic                        o_TX_Ready,
  output logic                        o_TX_Serial,
  output logic                        o_TX_Active,
  output logic                        o_TX_Done,
  output logic                        o_Overflow,
  output logic [$clog2(FIFO_DEPTH):0] o_FIFO_Count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
  localparam logic          PAR_INIT  = (PARITY == PARITY_ODD);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_db
    $error("DATA_BITS must be 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fd
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  tx_state_e            state;
  tx_state_e            state_n;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_n;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        idx_n;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_n;
  logic                 par;
  logic                 par_n;
  logic                 pop;
  logic                 stop_end;
  logic                 line;
  logic                 done_d;
  logic                 tick;
  logic [DATA_BITS-1:0] head;
  logic                 full;
  logic                 empty;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_Clock),
    .rst   (i_Rst),
    .write (i_TX_DV && o_TX_Ready),
    .wdata (i_TX_Byte),
    .read  (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (o_FIFO_Count)
  );

  assign o_TX_Ready = !full;
  assign tick       = (cnt == '0);

  // FSM and datapath state register
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      par   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      par   <= par_n;
    end
  end

  // next state, pop request and end-of-frame detect
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shift_n  = shift;
    par_n    = par;
    pop      = 1'b0;
    stop_end = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          cnt_n   = CNT_MAX;
          idx_n   = '0;
          par_n   = PAR_INIT;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          cnt_n   = CNT_MAX;
          state_n = ST_DATA;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      ST_DATA: begin
        if (tick) begin
          cnt_n   = CNT_MAX;
          shift_n = shift >> 1;
          par_n   = par ^ shift[0];
          if (idx == LAST_BIT) begin
            idx_n   = '0;
            state_n = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_n = idx + IW'(1);
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      ST_PARITY: begin
        if (tick) begin
          cnt_n   = CNT_MAX;
          idx_n   = '0;
          state_n = ST_STOP;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      ST_STOP: begin
        if (tick) begin
          cnt_n = CNT_MAX;
          if (idx == LAST_STOP) begin
            stop_end = 1'b1;
            idx_n    = '0;
            if (!empty) begin
              pop     = 1'b1;
              shift_n = head;
              par_n   = PAR_INIT;
              state_n = ST_START;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            idx_n = idx + IW'(1);
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // line level implied by the current state
  always_comb begin
    line = 1'b1;
    unique case (state)
      ST_START:  line = 1'b0;
      ST_DATA:   line = shift[0];
      ST_PARITY: line = par;
      default:   line = 1'b1;
    endcase
  end

  // registered outputs; done is delayed to line up with the last stop bit
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
      o_Overflow  <= 1'b0;
      done_d      <= 1'b0;
    end else begin
      o_TX_Serial <= line;
      o_TX_Active <= (state != ST_IDLE);
      done_d      <= stop_end;
      o_TX_Done   <= done_d;
      o_Overflow  <= i_TX_DV && full;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed checks for uart_tx_fifo across three configurations.
// A: 8N1 depth 4, B: 7E2, C: 8O1; all at 4 clocks per bit.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_a;
  logic       rst_bc;
  logic [2:0] dv;
  logic [7:0] byte_a;
  logic [6:0] byte_b;
  logic [7:0] byte_c;
  logic [2:0] rdy;
  logic [2:0] ser;
  logic [2:0] act;
  logic [2:0] done;
  logic [2:0] ovf;
  logic [2:0] cnt_a;
  logic [4:0] cnt_b;
  logic [4:0] cnt_c;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt_a = 0;
  logic cap_on = 1'b0;
  logic capq [$];

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLKS_PER_BIT (4), .DATA_BITS (8), .PARITY (0),
    .STOP_BITS (1), .FIFO_DEPTH (4)
  ) u_a (
    .i_Clock (clk), .i_Rst (rst_a), .i_TX_DV (dv[0]),
    .i_TX_Byte (byte_a), .o_TX_Ready (rdy[0]),
    .o_TX_Serial (ser[0]), .o_TX_Active (act[0]),
    .o_TX_Done (done[0]), .o_Overflow (ovf[0]),
    .o_FIFO_Count (cnt_a)
  );

  uart_tx_fifo #(
    .CLKS_PER_BIT (4), .DATA_BITS (7), .PARITY (2),
    .STOP_BITS (2), .FIFO_DEPTH (16)
  ) u_b (
    .i_Clock (clk), .i_Rst (rst_bc), .i_TX_DV (dv[1]),
    .i_TX_Byte (byte_b), .o_TX_Ready (rdy[1]),
    .o_TX_Serial (ser[1]), .o_TX_Active (act[1]),
    .o_TX_Done (done[1]), .o_Overflow (ovf[1]),
    .o_FIFO_Count (cnt_b)
  );

  uart_tx_fifo #(
    .CLKS_PER_BIT (4), .DATA_BITS (8), .PARITY (1),
    .STOP_BITS (1), .FIFO_DEPTH (16)
  ) u_c (
    .i_Clock (clk), .i_Rst (rst_bc), .i_TX_DV (dv[2]),
    .i_TX_Byte (byte_c), .o_TX_Ready (rdy[2]),
    .o_TX_Serial (ser[2]), .o_TX_Active (act[2]),
    .o_TX_Done (done[2]), .o_Overflow (ovf[2]),
    .o_FIFO_Count (cnt_c)
  );

  // count done pulses of A and record its line when asked
  always @(negedge clk) begin
    if (done[0]) done_cnt_a++;
    if (cap_on) capq.push_back(ser[0]);
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input int u, input logic [7:0] v);
    case (u)
      0:       byte_a = v;
      1:       byte_b = v[6:0];
      default: byte_c = v;
    endcase
    dv[u] = 1'b1;
    @(posedge clk);
    #1;
    dv[u] = 1'b0;
  endtask

  task automatic add_frame(inout logic [127:0] s,
                           inout logic [127:0] d,
                           inout int p,
                           input logic [7:0] w,
                           input int nb, input int pm,
                           input logic pb, input int ns);
    logic [11:0] f;
    int n;
    f = '0;
    f[0] = 1'b0;
    for (int j = 0; j < nb; j++) f[1+j] = w[j];
    n = 1 + nb;
    if (pm != 0) begin
      f[n] = pb;
      n++;
    end
    for (int j = 0; j < ns; j++) f[n+j] = 1'b1;
    n += ns;
    for (int k = 0; k < n; k++)
      for (int r = 0; r < 4; r++) s[p+4*k+r] = f[k];
    p += 4 * n;
    d[p] = 1'b1;
  endtask

  // capture from the first start-bit cycle and compare line/active/done
  task automatic run_frames(input string tag, input int u, input int nw,
                            input logic [7:0] w [3],
                            input int nb, input int pm,
                            input logic pb [3], input int ns);
    logic [127:0] es, ea, ed, gs, ga, gd;
    int p;
    es = '0; ea = '0; ed = '0;
    gs = '0; ga = '0; gd = '0;
    p = 0;
    for (int i = 0; i < nw; i++)
      add_frame(es, ed, p, w[i], nb, pm, pb[i], ns);
    es[p] = 1'b1;
    for (int i = 0; i < p; i++) ea[i] = 1'b1;
    for (int i = 0; i <= p; i++) begin
      @(negedge clk);
      gs[i] = ser[u];
      ga[i] = act[u];
      gd[i] = done[u];
    end
    chk({tag, "_ser"}, gs, es);
    chk({tag, "_act"}, ga, ea);
    chk({tag, "_done"}, gd, ed);
  endtask

  initial begin
    int ec [7];
    int er [7];
    int eo [7];
    logic [20:0] gc, xc;
    logic [6:0]  gr, xr, go, xo;
    int d0, p, st, zeros, bad;
    logic [15:0] gw;

    ec = '{1, 1, 2, 3, 4, 4, 4};
    er = '{1, 1, 1, 1, 0, 0, 0};
    eo = '{0, 0, 0, 0, 0, 1, 1};
    rst_a = 1'b1;
    rst_bc = 1'b1;
    dv = '0;
    byte_a = '0;
    byte_b = '0;
    byte_c = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ser", 128'(ser[0]), 128'(1));
    chk("rst_act", 128'(act[0]), 128'(0));
    chk("rst_done", 128'(done[0]), 128'(0));
    chk("rst_ovf", 128'(ovf[0]), 128'(0));
    chk("rst_rdy", 128'(rdy[0]), 128'(1));
    chk("rst_cnt", 128'(cnt_a), 128'(0));
    rst_a = 1'b0;
    rst_bc = 1'b0;
    @(posedge clk);
    #1;

    // 0x55 8N1: latency then full frame
    wr(0, 8'h55);
    @(negedge clk);
    chk("lat_cnt_n", 128'(cnt_a), 128'(1));
    chk("lat_ser_n", 128'(ser[0]), 128'(1));
    @(negedge clk);
    chk("lat_cnt_n1", 128'(cnt_a), 128'(0));
    chk("lat_ser_n1", 128'(ser[0]), 128'(1));
    chk("lat_act_n1", 128'(act[0]), 128'(0));
    run_frames("f55", 0, 1, '{8'h55, 8'h00, 8'h00}, 8, 0,
               '{1'b0, 1'b0, 1'b0}, 1);

    // three back-to-back frames
    dv[0] = 1'b1;
    byte_a = 8'hA1;
    @(posedge clk);
    #1;
    byte_a = 8'hB2;
    @(posedge clk);
    #1;
    byte_a = 8'hC3;
    @(posedge clk);
    #1;
    dv[0] = 1'b0;
    run_frames("b2b", 0, 3, '{8'hA1, 8'hB2, 8'hC3}, 8, 0,
               '{1'b0, 1'b0, 1'b0}, 1);

    // 7E2 on B and 8O1 on C
    wr(1, 8'h41);
    repeat (2) @(negedge clk);
    run_frames("e7_41", 1, 1, '{8'h41, 8'h00, 8'h00}, 7, 2,
               '{1'b0, 1'b0, 1'b0}, 2);
    wr(2, 8'h07);
    repeat (2) @(negedge clk);
    run_frames("o8_07", 2, 1, '{8'h07, 8'h00, 8'h00}, 8, 1,
               '{1'b0, 1'b0, 1'b0}, 1);
    wr(2, 8'h03);
    repeat (2) @(negedge clk);
    run_frames("o8_03", 2, 1, '{8'h03, 8'h00, 8'h00}, 8, 1,
               '{1'b1, 1'b0, 1'b0}, 1);

    // overflow: hold DV for 7 edges into a depth-4 FIFO
    d0 = done_cnt_a;
    capq.delete();
    cap_on = 1'b1;
    dv[0] = 1'b1;
    byte_a = 8'h10;
    gc = '0; xc = '0; gr = '0; xr = '0; go = '0; xo = '0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      gc[3*k +: 3] = cnt_a;
      xc[3*k +: 3] = 3'(ec[k]);
      gr[k] = rdy[0];
      xr[k] = er[k] != 0;
      go[k] = ovf[0];
      xo[k] = eo[k] != 0;
      byte_a = 8'(8'h11 + k);
    end
    dv[0] = 1'b0;
    chk("ovf_cnt", 128'(gc), 128'(xc));
    chk("ovf_rdy", 128'(gr), 128'(xr));
    chk("ovf_pulse", 128'(go), 128'(xo));
    @(posedge clk);
    #1;
    chk("ovf_clear", 128'(ovf[0]), 128'(0));
    repeat (220) @(negedge clk);
    cap_on = 1'b0;
    chk("ovf_ndone", 128'(done_cnt_a - d0), 128'(5));
    p = 0;
    for (int f = 0; f < 5; f++) begin
      st = -1;
      for (int i = p; i + 40 <= capq.size(); i++) begin
        if (capq[i] == 1'b0) begin
          st = i;
          break;
        end
      end
      gw = 16'hFFFF;
      if (st >= 0) begin
        gw = '0;
        for (int j = 0; j < 8; j++) gw[j] = capq[st + 4*(1+j) + 1];
        gw[8] = capq[st + 37];
        p = st + 40;
      end
      chk("ovf_word", 128'(gw), 128'({8'h01, 8'(8'h10 + f)}));
    end
    zeros = 0;
    for (int i = p; i < capq.size(); i++)
      if (capq[i] == 1'b0) zeros++;
    chk("ovf_tail", 128'(zeros), 128'(0));

    // reset during data bit 3 with two words queued
    d0 = done_cnt_a;
    dv[0] = 1'b1;
    byte_a = 8'h00;
    @(posedge clk);
    #1;
    byte_a = 8'h3C;
    @(posedge clk);
    #1;
    byte_a = 8'h99;
    @(posedge clk);
    #1;
    dv[0] = 1'b0;
    @(negedge clk);
    chk("mrst_q", 128'(cnt_a), 128'(2));
    repeat (17) @(posedge clk);
    #1;
    chk("mrst_pre_ser", 128'(ser[0]), 128'(0));
    chk("mrst_pre_act", 128'(act[0]), 128'(1));
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_ser", 128'(ser[0]), 128'(1));
    chk("mrst_cnt", 128'(cnt_a), 128'(0));
    chk("mrst_act", 128'(act[0]), 128'(0));
    chk("mrst_rdy", 128'(rdy[0]), 128'(1));
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    bad = 0;
    repeat (120) begin
      @(negedge clk);
      if (ser[0] !== 1'b1 || act[0] !== 1'b0) bad++;
    end
    chk("mrst_quiet", 128'(bad), 128'(0));
    chk("mrst_ndone", 128'(done_cnt_a - d0), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
